// File: rtl/hps_pio_handshake.sv
// Multi-channel HPS output PIO with per-channel valid/ready handshake, sticky done/overflow status.
// Optional interrupt (IRQ_MASK register and irq port) enabled by defining HPS_PIO_HANDSHAKE_IRQ_EN.
module hps_pio_handshake #(
    parameter int                DATA_W    = 10,
    parameter int                NUM_CH    = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready
`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_MASK   = 3'd5;
    localparam logic [2:0] ADDR_OVF    = 3'd7;

    logic              wr;
    logic [DATA_W-1:0] data_q  [NUM_CH];
    logic [0:0]        state_q [NUM_CH];
    logic [0:0]        state_d [NUM_CH];
    logic [NUM_CH-1:0] data_wr;
    logic [NUM_CH-1:0] xfer;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] done_clr;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] ovf_clr;
    logic [NUM_CH-1:0] mask_rd;
    logic              unused_wdata;

    assign wr = chipselect & ~write_n;

    // Upper writedata bits are deliberately dropped for narrow channels.
    assign unused_wdata = ^{1'b0, writedata};

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            out_valid[c] = (state_q[c] == ST_PEND);
        end
    end

    assign xfer = out_valid & out_ready;

    always_comb begin
        data_wr = '0;
        ovf_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            data_wr[c] = wr && (address == 3'(c));
            ovf_set[c] = data_wr[c] & out_valid[c] & ~out_ready[c];
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_IDLE: if (data_wr[c]) state_d[c] = ST_PEND;
                ST_PEND: if (!data_wr[c] && out_ready[c]) state_d[c] = ST_IDLE;
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    assign done_clr = (wr && address == ADDR_STATUS) ? writedata[8 +: NUM_CH] : '0;
    assign ovf_clr  = (wr && address == ADDR_OVF)    ? writedata[NUM_CH-1:0] : '0;

    // Sticky bits: a set in the same cycle as a W1C clear takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_q[c]  <= RESET_VAL;
                state_q[c] <= ST_IDLE;
            end
            done_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (data_wr[c]) data_q[c] <= writedata[DATA_W-1:0];
                state_q[c] <= state_d[c];
            end
            done_q <= (done_q & ~done_clr) | xfer;
            ovf_q  <= (ovf_q & ~ovf_clr) | ovf_set;
        end
    end

`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
    logic [NUM_CH-1:0] mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr && address == ADDR_MASK) mask_q <= writedata[NUM_CH-1:0];
            irq <= |(done_q & mask_q);
        end
    end

    assign mask_rd = mask_q;
`else
    assign mask_rd = '0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_port
        assign out_port[c*DATA_W +: DATA_W] = data_q[c];
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STATUS: begin
                readdata[NUM_CH-1:0] = out_valid;
                readdata[8 +: NUM_CH] = done_q;
            end
            ADDR_MASK: readdata[NUM_CH-1:0] = mask_rd;
            ADDR_OVF:  readdata[NUM_CH-1:0] = ovf_q;
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (address == 3'(c)) readdata[DATA_W-1:0] = data_q[c];
                end
            end
        endcase
    end

endmodule

// File: tb/tb_hps_pio_handshake.sv
// Directed self-checking bench for hps_pio_handshake (DATA_W=10, NUM_CH=2, RESET_VAL=0).
// Define HPS_PIO_HANDSHAKE_IRQ_EN to also exercise the interrupt path.
module tb_hps_pio_handshake;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [19:0] out_port;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
    logic        irq;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd;

    hps_pio_handshake #(
        .DATA_W   (10),
        .NUM_CH   (2),
        .RESET_VAL(10'h000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Single-cycle Avalon write; returns 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        address    = addr;
        writedata  = wdata;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readRegister(input logic [2:0] addr, output logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        data       = readdata;
        chipselect = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        out_ready  = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idleCycle();

        $display("[TB] reset state");
        readRegister(3'd0, rd); checkOutput("rst_data0", rd, 32'h0);
        readRegister(3'd1, rd); checkOutput("rst_data1", rd, 32'h0);
        idleCycle();
        readRegister(3'd4, rd); checkOutput("rst_status", rd, 32'h0);
        readRegister(3'd7, rd); checkOutput("rst_ovf", rd, 32'h0);
        checkOutput("rst_valid", 32'(out_valid), 32'h0);

        $display("[TB] basic ch0 handshake");
        applyStimulus(3'd0, 32'h3FF);
        checkOutput("ch0_port", 32'(out_port[9:0]), 32'h3FF);
        checkOutput("ch0_valid", 32'(out_valid), 32'h1);
        repeat (5) idleCycle();
        checkOutput("ch0_hold_valid", 32'(out_valid), 32'h1);
        checkOutput("ch0_hold_port", 32'(out_port[9:0]), 32'h3FF);
        out_ready = 2'b01;
        idleCycle();
        out_ready = 2'b00;
        checkOutput("ch0_after_xfer_valid", 32'(out_valid), 32'h0);
        readRegister(3'd4, rd); checkOutput("ch0_done", rd, 32'h100);
        applyStimulus(3'd4, 32'h100);
        readRegister(3'd4, rd); checkOutput("ch0_done_w1c", rd, 32'h0);

        $display("[TB] ch1 overflow");
        applyStimulus(3'd1, 32'h12);
        applyStimulus(3'd1, 32'h34);
        readRegister(3'd7, rd); checkOutput("ch1_ovf", rd, 32'h2);
        checkOutput("ch1_port", 32'(out_port[19:10]), 32'h34);
        checkOutput("ch1_valid", 32'(out_valid), 32'h2);
        applyStimulus(3'd7, 32'h2);
        readRegister(3'd7, rd); checkOutput("ch1_ovf_w1c", rd, 32'h0);

        $display("[TB] write during transfer");
        out_ready = 2'b10;
        applyStimulus(3'd1, 32'h55);
        out_ready = 2'b00;
        checkOutput("sim_valid", 32'(out_valid), 32'h2);
        checkOutput("sim_port", 32'(out_port[19:10]), 32'h55);
        readRegister(3'd4, rd); checkOutput("sim_status", rd, 32'h202);
        readRegister(3'd7, rd); checkOutput("sim_no_ovf", rd, 32'h0);
        out_ready = 2'b10;
        idleCycle();
        out_ready = 2'b00;
        checkOutput("sim_drain_valid", 32'(out_valid), 32'h0);
        checkOutput("sim_drain_port", 32'(out_port[19:10]), 32'h55);
        applyStimulus(3'd4, 32'h200);
        readRegister(3'd4, rd); checkOutput("sim_done_w1c", rd, 32'h0);

        $display("[TB] write in idle with ready high");
        out_ready = 2'b01;
        applyStimulus(3'd0, 32'h1);
        readRegister(3'd4, rd); checkOutput("idle_rdy_status", rd, 32'h001);
        idleCycle();
        out_ready = 2'b00;
        readRegister(3'd4, rd); checkOutput("idle_rdy_xfer", rd, 32'h100);
        applyStimulus(3'd4, 32'h100);

        $display("[TB] width truncation and unmapped offsets");
        applyStimulus(3'd0, 32'hFFFF_FFFF);
        readRegister(3'd0, rd); checkOutput("trunc_read", rd, 32'h3FF);
        out_ready = 2'b01;
        idleCycle();
        out_ready = 2'b00;
        applyStimulus(3'd4, 32'h100);
        applyStimulus(3'd3, 32'hABC);
        applyStimulus(3'd6, 32'h3);
        readRegister(3'd3, rd); checkOutput("off3_read", rd, 32'h0);
        readRegister(3'd6, rd); checkOutput("off6_read", rd, 32'h0);
        readRegister(3'd0, rd); checkOutput("off3_no_side", rd, 32'h3FF);
        checkOutput("unmapped_valid", 32'(out_valid), 32'h0);
        checkOutput("unmapped_port", 32'(out_port), 32'h157FF);
`ifndef HPS_PIO_HANDSHAKE_IRQ_EN
        applyStimulus(3'd5, 32'h3);
        readRegister(3'd5, rd); checkOutput("mask_absent", rd, 32'h0);
`endif

        $display("[TB] set beats W1C");
        applyStimulus(3'd0, 32'h7);
        out_ready = 2'b01;
        applyStimulus(3'd4, 32'h100);
        out_ready = 2'b00;
        readRegister(3'd4, rd); checkOutput("set_wins", rd, 32'h100);
        applyStimulus(3'd4, 32'h100);
        readRegister(3'd4, rd); checkOutput("set_wins_clear", rd, 32'h0);

`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
        $display("[TB] interrupt");
        applyStimulus(3'd5, 32'h1);
        readRegister(3'd5, rd); checkOutput("mask_read", rd, 32'h1);
        checkOutput("irq_idle", 32'(irq), 32'h0);
        applyStimulus(3'd0, 32'h9);
        out_ready = 2'b01;
        idleCycle();
        out_ready = 2'b00;
        checkOutput("irq_not_yet", 32'(irq), 32'h0);
        idleCycle();
        checkOutput("irq_set", 32'(irq), 32'h1);
        applyStimulus(3'd4, 32'h100);
        checkOutput("irq_hold", 32'(irq), 32'h1);
        idleCycle();
        checkOutput("irq_clear", 32'(irq), 32'h0);
        applyStimulus(3'd5, 32'h3);
        applyStimulus(3'd1, 32'h76);
        out_ready = 2'b10;
        idleCycle();
        out_ready = 2'b00;
        idleCycle();
        checkOutput("irq_ch1", 32'(irq), 32'h1);
`endif

        $display("[TB] reset mid-handshake");
        applyStimulus(3'd1, 32'h77);
        checkOutput("pre_rst_valid", 32'(out_valid), 32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
        checkOutput("mid_rst_port", 32'(out_port), 32'h0);
        readRegister(3'd4, rd); checkOutput("mid_rst_status", rd, 32'h0);
        readRegister(3'd7, rd); checkOutput("mid_rst_ovf", rd, 32'h0);
`ifdef HPS_PIO_HANDSHAKE_IRQ_EN
        checkOutput("mid_rst_irq", 32'(irq), 32'h0);
        readRegister(3'd5, rd); checkOutput("mid_rst_mask", rd, 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        idleCycle();
        readRegister(3'd1, rd); checkOutput("post_rst_data1", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
